// File: rtl/conv_enc_pkg.sv
// Shared types and constants for the rate-1/2 convolutional encoder frame controller.
package conv_enc_pkg;

  typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} state_t;

  // Generator polynomials; the MSB multiplies the newest input bit.
  localparam logic [2:0] G_K3_1 = 3'o7;
  localparam logic [2:0] G_K3_2 = 3'o5;
  localparam logic [6:0] G_K7_1 = 7'o171;
  localparam logic [6:0] G_K7_2 = 7'o133;

  localparam logic [2:0] TAIL_K3 = 3'd2;
  localparam logic [2:0] TAIL_K7 = 3'd6;

endpackage

// File: rtl/conv_enc_core.sv
// Shift-register convolutional encoder (K=3 or K=7) with a registered coded pair.
module conv_enc_core
  import conv_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  input  logic       k_sel,
  input  logic       u,
  output logic [1:0] pair
);

  logic [5:0] sr;
  logic [6:0] taps;
  logic [1:0] code;

  // taps[6] is the incoming bit, taps[5] the previous one, and so on.
  always_comb begin
    taps = {u, sr[0], sr[1], sr[2], sr[3], sr[4], sr[5]};
    if (k_sel) begin
      code = {^(taps & G_K7_1), ^(taps & G_K7_2)};
    end else begin
      code = {^(taps[6:4] & G_K3_1), ^(taps[6:4] & G_K3_2)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      pair <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (advance) begin
      pair <= code;
      // K=3 keeps the upper four stages at zero.
      sr   <= k_sel ? {sr[4:0], u} : {4'b0, sr[0], u};
    end
  end

endmodule

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer: pulls data bits, appends K-1 tail zeros, emits coded pairs with backpressure.
// Optional puncturing (rate 2/3, pattern [11;10]) is enabled by defining CONV_PUNCTURE_EN.
module conv_enc_frame_ctrl
  import conv_enc_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             choose_constraint_length,
`ifdef CONV_PUNCTURE_EN
  input  logic             punct_en,
  output logic [1:0]       out_mask,
`endif
  output logic             busy,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       out_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and a held pair stays stable until taken.

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, bit_cnt;
  logic             k_q;
  logic [2:0]       tail_cnt, tail_len;
  logic             advance, clear, u, last_adv, accept, adv_ok;

  assign tail_len = k_q ? TAIL_K7 : TAIL_K3;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    advance   = 1'b0;
    clear     = 1'b0;
    u         = 1'b0;
    last_adv  = 1'b0;
    accept    = out_valid && out_ready;
    adv_ok    = !out_valid || out_ready;
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = (frame_len == '0) ? TAIL : DATA;
        end
      end
      DATA: begin
        in_ready = adv_ok;
        if (in_valid && adv_ok) begin
          advance = 1'b1;
          u       = in_bit;
          if (bit_cnt == len_q - 1'b1) state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (adv_ok) begin
          advance = 1'b1;
          if (tail_cnt == tail_len - 3'd1) begin
            last_adv  = 1'b1;
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      k_q       <= 1'b0;
      bit_cnt   <= '0;
      tail_cnt  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == FLUSH) && accept;
      if (clear) begin
        len_q    <= frame_len;
        k_q      <= choose_constraint_length;
        bit_cnt  <= '0;
        tail_cnt <= '0;
      end
      if (state == DATA && advance) bit_cnt  <= bit_cnt + 1'b1;
      if (state == TAIL && advance) tail_cnt <= tail_cnt + 3'd1;
      if (advance) begin
        out_valid <= 1'b1;
        out_last  <= last_adv;
      end else if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef CONV_PUNCTURE_EN
  logic punct_q, n_odd;

  always_ff @(posedge clk) begin
    if (rst) begin
      punct_q  <= 1'b0;
      n_odd    <= 1'b0;
      out_mask <= 2'b00;
    end else begin
      if (clear) begin
        punct_q <= punct_en;
        n_odd   <= 1'b0;
      end
      if (advance) begin
        out_mask <= (punct_q && n_odd) ? 2'b10 : 2'b11;
        n_odd    <= ~n_odd;
      end
    end
  end
`endif

  conv_enc_core u_core (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .k_sel   (k_q),
    .u       (u),
    .pair    (out_bits)
  );

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Directed self-checking bench for conv_enc_frame_ctrl (hand-computed coded pair sequences).
module tb_conv_enc_frame_ctrl;

  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             rst, start, choose, in_bit, in_valid, out_ready;
  logic [LEN_W-1:0] frame_len;
  logic             busy, in_ready, out_valid, out_last, done;
  logic [1:0]       out_bits;
`ifdef CONV_PUNCTURE_EN
  logic             punct_en;
  logic [1:0]       out_mask;
`endif

  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] exp_q[$];
  logic [3:0] rdy_pat = 4'b1001;

  always #5 clk = ~clk;

  conv_enc_frame_ctrl #(.LEN_W(LEN_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .frame_len                (frame_len),
    .choose_constraint_length (choose),
`ifdef CONV_PUNCTURE_EN
    .punct_en                 (punct_en),
    .out_mask                 (out_mask),
`endif
    .busy                     (busy),
    .in_bit                   (in_bit),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .out_bits                 (out_bits),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .out_last                 (out_last),
    .done                     (done)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_busy",      16'(busy),      16'd0);
    check("rst_in_ready",  16'(in_ready),  16'd0);
    check("rst_out_bits",  16'(out_bits),  16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_last",  16'(out_last),  16'd0);
    check("rst_done",      16'(done),      16'd0);
`ifdef CONV_PUNCTURE_EN
    check("rst_out_mask",  16'(out_mask),  16'd0);
`endif
  endtask

  // Called on a falling edge; runs one frame and checks every accepted pair against exp_q.
  task automatic run_frame(input logic k, input logic [LEN_W-1:0] len, input logic [15:0] bits,
                           input logic stall, input logic pe, input logic busy_start);
    int         n_pairs, got, sent, cyc;
    logic [1:0] held, ep;
    logic       stalled, fin;
    n_pairs = exp_q.size();
    start = 1'b1; frame_len = len; choose = k;
`ifdef CONV_PUNCTURE_EN
    punct_en = pe;
`endif
    @(negedge clk);
    start = 1'b0; frame_len = 12'd7; choose = ~k;
    check("busy_after_start", 16'(busy), 16'd1);
    got = 0; sent = 0; cyc = 0; stalled = 1'b0; fin = 1'b0; held = 2'b00;
    while (!fin && cyc < 300) begin
      if (got == n_pairs) begin
        check("done_pulse", 16'(done), 16'd1);
        fin = 1'b1;
      end else begin
        check("no_early_done", 16'(done), 16'd0);
        if (stalled) begin
          check("hold_valid", 16'(out_valid), 16'd1);
          check("hold_bits",  16'(out_bits),  16'(held));
        end
        out_ready = stall ? rdy_pat[cyc[1:0]] : 1'b1;
        in_valid  = (sent < int'(len));
        in_bit    = bits[sent[3:0]];
        if (busy_start && cyc < 2) begin
          start = 1'b1; frame_len = 12'd5; choose = 1'b1;
        end else begin
          start = 1'b0;
        end
        #1;
        if (out_valid && !out_ready) check("stall_in_ready", 16'(in_ready), 16'd0);
        if (len == '0) check("zero_len_in_ready", 16'(in_ready), 16'd0);
        stalled = out_valid && !out_ready;
        held    = out_bits;
        if (in_valid && in_ready) sent++;
        if (out_valid && out_ready) begin
          if (exp_q.size() > 0) ep = exp_q.pop_front();
          else ep = 2'bxx;
          check("pair", 16'(out_bits), 16'(ep));
          check("last", 16'(out_last), 16'(got == n_pairs - 1));
`ifdef CONV_PUNCTURE_EN
          check("mask", 16'(out_mask), (pe && got[0]) ? 16'h2 : 16'h3);
`endif
          got++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    check("frame_complete", 16'(fin), 16'd1);
    check("bits_consumed", 16'(sent), 16'(len));
    @(negedge clk);
    check("done_cleared", 16'(done), 16'd0);
    check("idle_after", 16'(busy), 16'd0);
  endtask

  initial begin
    int sent;
    rst = 1'b1; start = 1'b0; frame_len = '0; choose = 1'b0;
    in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef CONV_PUNCTURE_EN
    punct_en = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    // K=3, bits 1,0,1,1, no backpressure
    exp_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    run_frame(1'b0, 12'd4, 16'b1101, 1'b0, 1'b0, 1'b0);

    // K=7 impulse response
    exp_q = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    run_frame(1'b1, 12'd1, 16'b0001, 1'b0, 1'b0, 1'b0);

    // K=3 with out_ready toggling 1,0,0,1
    exp_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    run_frame(1'b0, 12'd4, 16'b1101, 1'b1, 1'b0, 1'b0);

    // Empty frame, start pulsed while busy
    exp_q = '{2'b00, 2'b00};
    run_frame(1'b0, 12'd0, 16'b0000, 1'b0, 1'b0, 1'b1);

    // Reset after the 2nd accepted bit
    start = 1'b1; frame_len = 12'd4; choose = 1'b0;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1; in_valid = 1'b1; sent = 0;
    for (int i = 0; i < 20 && sent < 2; i++) begin
      in_bit = (sent == 1) ? 1'b0 : 1'b1;
      #1;
      if (in_ready) sent++;
      @(negedge clk);
    end
    check("bits_before_rst", 16'(sent), 16'd2);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    check("no_done_after_abort", 16'(done), 16'd0);

    exp_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    run_frame(1'b0, 12'd4, 16'b1101, 1'b0, 1'b0, 1'b0);

`ifdef CONV_PUNCTURE_EN
    exp_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    run_frame(1'b0, 12'd4, 16'b1101, 1'b0, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_enc_frame_ctrl.md
Name: conv_enc_frame_ctrl

Overview:
- Frame sequencer for the rate-1/2 convolutional encoder datapath.
- Accepts a frame start with a length, pulls data bits from an upstream source over a valid/ready handshake, and runs them through an embedded shift-register encoder (K=3 or K=7, chosen per frame).
- Appends K-1 zero tail bits to flush the encoder, then presents coded bit pairs downstream with backpressure and a last marker.
- Sits between the bit source and the modulator/serializer.

Parameters:
- LEN_W, 12, width of the frame_len input; maximum frame is 2^LEN_W-1 data bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- frame_len  in  LEN_W  number of data bits; sampled with start.
- choose_constraint_length  in  1  0: K=3, generators 7,5 octal; 1: K=7, generators 171,133 octal. Sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- in_bit  in  1  data bit.
- in_valid  in  1  data bit valid.
- in_ready  out  1  block accepts in_bit this cycle.
- out_bits  out  2  [1]=generator-1 output, [0]=generator-2 output.
- out_valid  out  1  out_bits valid.
- out_ready  in  1  downstream accepts out_bits.
- out_last  out  1  marks the final (last tail) pair of the frame.
- done  out  1  one-cycle pulse after the last pair is accepted.

Behaviour:
- Reset values: busy=0, in_ready=0, out_bits=0, out_valid=0, out_last=0, done=0. Shift register cleared. State IDLE.
- State machine:
  - IDLE: on start, latch frame_len and K, clear the shift register and pair counter. Go to DATA, or to TAIL if frame_len==0.
  - DATA: in_ready = !out_valid || out_ready. Each in_valid && in_ready consumes one bit. After frame_len bits, go to TAIL.
  - TAIL: inject K-1 zero bits under the same advance condition (!out_valid || out_ready), with no upstream handshake. Go to FLUSH.
  - FLUSH: wait until the final pair is accepted. Pulse done, return to IDLE.
- Encoder advance: each consumed bit u (data or tail) registers out_bits and sets out_valid on the next edge, so latency is 1 cycle.
  - Outputs are the XOR of the generator taps over {u, state}; the generator MSB multiplies u.
  - The shift register takes u as its newest element.
- Output register hold: out_valid and out_bits hold stable while out_valid && !out_ready. out_valid clears when the pair is accepted and no new bit advances in the same cycle.
- Throughput: one pair per cycle with out_ready held high; no bubbles between DATA and TAIL.
- out_last is high together with the pair produced by the final tail bit.
- start while busy is ignored. frame_len and choose_constraint_length are ignored outside IDLE.
- Total pairs per frame = frame_len + K - 1.
- An in_valid bit that is not accepted is never consumed.
- rst mid-frame: abort immediately to reset values. No done pulse, no partial flush.
- The K=3 configuration only uses the 2 low stages of the 6-bit shift register. Unused stages are held at 0.

Optional Feature:
- Macro: CONV_PUNCTURE_EN.
- When defined:
  - Adds input punct_en (1) and output out_mask (2), both sampled/driven per frame. punct_en is sampled with start.
  - When punct_en=1, pattern [11;10] gives rate 2/3. Pair index n counts from 0 per frame across data and tail.
  - Even n: out_mask=2'b11. Odd n: out_mask=2'b10.
  - out_bits are always driven in full; the mask only qualifies them.
  - When punct_en=0: out_mask=2'b11.
  - out_mask resets to 2'b00.
- When not defined: no extra ports; behaviour identical to unpunctured operation.

Decomposition:
- Package conv_enc_pkg holds:
  - state enum {IDLE, DATA, TAIL, FLUSH};
  - generator constants G_K3_1=3'o7, G_K3_2=3'o5, G_K7_1=7'o171, G_K7_2=7'o133;
  - tail lengths TAIL_K3=2, TAIL_K7=6.
- One sub-module, conv_enc_core: shift register plus generator XOR with advance, clear and k_sel inputs and a registered 2-bit output. The FSM, counters, handshake and puncturing stay in the top.

Test Plan:
- K=3, frame_len=4, bits 1,0,1,1, out_ready=1 -> pairs 11,10,00,01,01,11; out_last on the 6th pair; done 1 cycle after it.
- K=7, frame_len=1, bit 1 -> pairs 11,10,11,11,00,01,11 (impulse response); out_last on the 7th.
- K=3, frame_len=4 as above with out_ready toggling 1,0,0,1,… -> same pair sequence; out_bits stable while stalled; in_ready low whenever out_valid && !out_ready.
- frame_len=0, K=3 -> in_ready never high; pairs 00,00; done pulse; start asserted during busy has no effect.
- rst asserted after the 2nd accepted bit -> next cycle all outputs at reset values; a following K=3 frame with 1,0,1,1 reproduces 11,10,00,01,01,11.
- CONV_PUNCTURE_EN, punct_en=1, K=3 frame 1,0,1,1 -> out_mask 11,10,11,10,11,10 with the unchanged out_bits sequence.
